cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Consumer end of the ALU flag interface: takes the ALU's 4-bit {N,Z,C,V} flag bus and holds the architectural flag register (NZCV).
- Evaluates the 4-bit ARM-style condition field of the current execute-stage instruction against the held flags.
- Gates that instruction's side effects (PC write, register write, memory write, flag write) by the result.
- Registers the gated controls into the memory stage.
- Sits between the decoder/control unit and the datapath, downstream of the ALU.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.
- FLAG_BYPASS, 0, if 1 cond evaluation sees flags being written in the same cycle (combinational path); if 0 it sees only the registered flags.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  execute-stage instruction is valid.
- stall  in  1  hold all state and outputs this cycle.
- flush  in  1  kill the execute-stage instruction.
- cond  in  4  instruction condition field.
- flag_w  in  2  [1]=write N,Z; [0]=write C,V.
- pc_src_d  in  1  decoded PC-write request.
- reg_write_d  in  1  decoded register-write request.
- mem_write_d  in  1  decoded memory-write request.
- no_write_d  in  1  compare-type instruction; suppresses register write.
- alu_flags  in  4  {N,Z,C,V} from ALU, bit3=N, bit0=V.
- cond_ex  out  1  combinational: condition passed for the current instruction.
- illegal_cond  out  1  combinational: ex_valid and cond==4'b1111.
- flags  out  4  registered NZCV.
- pc_src_m  out  1  registered gated PC write.
- reg_write_m  out  1  registered gated register write.
- mem_write_m  out  1  registered gated memory write.
- valid_m  out  1  registered: instruction advanced and not flushed.

Behaviour:
- Reset (synchronous, on clk edge while reset=1): flags<=RESET_FLAGS; pc_src_m, reg_write_m, mem_write_m, valid_m <= 0. Reset overrides stall and flush. Reset mid-instruction discards that instruction.
- Condition decode uses flags (or bypassed flags, see below):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
  - 1111 is reserved: cond_ex=0 and illegal_cond=1.
- cond_ex = ex_valid & !flush & decoded condition.
- Flag update, at clk edge when !stall & cond_ex:
  - flag_w[1]: flags[3:2] <= alu_flags[3:2].
  - flag_w[0]: flags[1:0] <= alu_flags[1:0].
  - Unwritten bits hold. A failed condition writes nothing.
- Bypass (FLAG_BYPASS=1): the value used for decode is flags with the pending write merged per flag_w. This is only for single-cycle use, where the write is from the previous instruction. It is not normally set. With FLAG_BYPASS=0, an instruction's condition sees flags written by instructions that updated on earlier edges. Back-to-back CMP then BEQ works with zero stall because CMP updates flags at the edge that advances BEQ into execute.
- Output register, at clk edge when !stall:
  - pc_src_m <= pc_src_d & cond_ex.
  - reg_write_m <= reg_write_d & !no_write_d & cond_ex.
  - mem_write_m <= mem_write_d & cond_ex.
  - valid_m <= ex_valid & !flush.
  - Latency 1 cycle.
- stall=1: flags and all *_m outputs hold, regardless of flag_w and cond. flush during stall: stall wins for registers. flush still forces cond_ex=0 combinationally.
- flush=1 (no stall): instruction treated as condition-failed. No flag write; *_m <= 0.
- ex_valid=0: cond_ex=0, no flag write, *_m <= 0.

Decomposition:
- Shared package holds:
  - condition code localparams COND_EQ..COND_AL, COND_RSVD.
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FLAG_W_NZ=2'b10, FLAG_W_CV=2'b01.
- One natural sub-module: cond_check, a purely combinational map of (cond, nzcv) to (pass, illegal). It is reusable by a future branch predictor.

Test Plan:
- Reset with RESET_FLAGS=4'b0000, then cond=EQ ex_valid=1 -> cond_ex=0, flags=0000, all *_m=0 after first edge.
- flag_w=2'b11, cond=AL, alu_flags=4'b0100 -> next cycle flags=0100. Then cond=EQ reg_write_d=1 -> cond_ex=1, reg_write_m=1 one cycle later.
- flags=0100, flag_w=2'b01, alu_flags=1011 -> flags=0111, with N and Z held. Then cond=HI -> cond_ex=0; cond=LS -> 1.
- flags=1000 (N=1,V=0): cond=LT -> cond_ex=1, GE -> 0, GT -> 0, LE -> 1. cond=1111 -> cond_ex=0, illegal_cond=1, no flag write even with flag_w=11.
- stall=1 with cond=AL, flag_w=11, alu_flags=1111, mem_write_d=1 -> flags and mem_write_m unchanged. Deassert stall -> flags=1111, mem_write_m=1.
- flush=1 with cond=AL, flag_w=11, pc_src_d=1 -> pc_src_m=0, valid_m=0, flags unchanged. Assert reset alongside stall -> flags=RESET_FLAGS next edge.

Source files
------------

// File: rtl/cond_logic_pkg.sv
// Shared definitions for the condition-evaluation slice: condition codes,
// NZCV bit positions and flag-write enables.
package cond_logic_pkg;

  localparam logic [3:0] COND_EQ   = 4'h0;
  localparam logic [3:0] COND_NE   = 4'h1;
  localparam logic [3:0] COND_CS   = 4'h2;
  localparam logic [3:0] COND_CC   = 4'h3;
  localparam logic [3:0] COND_MI   = 4'h4;
  localparam logic [3:0] COND_PL   = 4'h5;
  localparam logic [3:0] COND_VS   = 4'h6;
  localparam logic [3:0] COND_VC   = 4'h7;
  localparam logic [3:0] COND_HI   = 4'h8;
  localparam logic [3:0] COND_LS   = 4'h9;
  localparam logic [3:0] COND_GE   = 4'hA;
  localparam logic [3:0] COND_LT   = 4'hB;
  localparam logic [3:0] COND_GT   = 4'hC;
  localparam logic [3:0] COND_LE   = 4'hD;
  localparam logic [3:0] COND_AL   = 4'hE;
  localparam logic [3:0] COND_RSVD = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAG_W_NZ = 2'b10;
  localparam logic [1:0] FLAG_W_CV = 2'b01;

  // Overlay the ALU flags onto the held flags for the enabled groups only.
  function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                             input logic [3:0] alu,
                                             input logic [1:0] fw);
    logic [3:0] res;
    res = cur;
    if ((fw & FLAG_W_NZ) != 2'b00) begin
      res[FLAG_N] = alu[FLAG_N];
      res[FLAG_Z] = alu[FLAG_Z];
    end
    if ((fw & FLAG_W_CV) != 2'b00) begin
      res[FLAG_C] = alu[FLAG_C];
      res[FLAG_V] = alu[FLAG_V];
    end
    return res;
  endfunction

endpackage

// File: rtl/cond_logic_cond_check.sv
// Purely combinational ARM-style condition evaluator: maps a condition field
// and an NZCV value to pass/illegal. Kept standalone for reuse.
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass,
  output logic       illegal
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass    = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_EQ:   pass = z;
      COND_NE:   pass = ~z;
      COND_CS:   pass = c;
      COND_CC:   pass = ~c;
      COND_MI:   pass = n;
      COND_PL:   pass = ~n;
      COND_VS:   pass = v;
      COND_VC:   pass = ~v;
      COND_HI:   pass = c & ~z;
      COND_LS:   pass = ~c | z;
      COND_GE:   pass = (n == v);
      COND_LT:   pass = (n != v);
      COND_GT:   pass = ~z & (n == v);
      COND_LE:   pass = z | (n != v);
      COND_AL:   pass = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Holds the NZCV register, evaluates the execute-stage condition and
// registers the condition-gated side-effect controls into the memory stage.
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         FLAG_BYPASS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic [1:0] flag_w,
  input  logic       pc_src_d,
  input  logic       reg_write_d,
  input  logic       mem_write_d,
  input  logic       no_write_d,
  input  logic [3:0] alu_flags,
  output logic       cond_ex,
  output logic       illegal_cond,
  output logic [3:0] flags,
  output logic       pc_src_m,
  output logic       reg_write_m,
  output logic       mem_write_m,
  output logic       valid_m
);

  logic [3:0] flags_d, flags_q;
  logic       pc_src_m_d, pc_src_m_q;
  logic       reg_write_m_d, reg_write_m_q;
  logic       mem_write_m_d, mem_write_m_q;
  logic       valid_m_d, valid_m_q;
  logic [3:0] dec_flags;
  logic       cc_pass, cc_illegal, pass_ex;

  // Bypass merges the pending write ungated by the pass result, which keeps
  // the decode free of a combinational loop through cond_ex.
  assign dec_flags = FLAG_BYPASS ? merge_flags(flags_q, alu_flags, flag_w) : flags_q;

  cond_check u_cond_check (
    .cond    (cond),
    .nzcv    (dec_flags),
    .pass    (cc_pass),
    .illegal (cc_illegal)
  );

  always_comb begin
    pass_ex       = ex_valid & ~flush & cc_pass;
    flags_d       = flags_q;
    pc_src_m_d    = pc_src_m_q;
    reg_write_m_d = reg_write_m_q;
    mem_write_m_d = mem_write_m_q;
    valid_m_d     = valid_m_q;
    if (!stall) begin
      if (pass_ex) flags_d = merge_flags(flags_q, alu_flags, flag_w);
      pc_src_m_d    = pc_src_d & pass_ex;
      reg_write_m_d = reg_write_d & ~no_write_d & pass_ex;
      mem_write_m_d = mem_write_d & pass_ex;
      valid_m_d     = ex_valid & ~flush;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q       <= RESET_FLAGS;
      pc_src_m_q    <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
      valid_m_q     <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      pc_src_m_q    <= pc_src_m_d;
      reg_write_m_q <= reg_write_m_d;
      mem_write_m_q <= mem_write_m_d;
      valid_m_q     <= valid_m_d;
    end
  end

  assign cond_ex      = pass_ex;
  assign illegal_cond = ex_valid & cc_illegal;
  assign flags        = flags_q;
  assign pc_src_m     = pc_src_m_q;
  assign reg_write_m  = reg_write_m_q;
  assign mem_write_m  = mem_write_m_q;
  assign valid_m      = valid_m_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed-vector bench for cond_logic with hand-computed expectations.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset, ex_valid, stall, flush;
  logic [3:0] cond;
  logic [1:0] flag_w;
  logic       pc_src_d, reg_write_d, mem_write_d, no_write_d;
  logic [3:0] alu_flags;
  logic       cond_ex, illegal_cond;
  logic [3:0] flags;
  logic       pc_src_m, reg_write_m, mem_write_m, valid_m;

  int n_vec = 0;
  int n_err = 0;

  cond_logic #(.RESET_FLAGS(4'b0000), .FLAG_BYPASS(1'b0)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .cond(cond), .flag_w(flag_w), .pc_src_d(pc_src_d), .reg_write_d(reg_write_d),
    .mem_write_d(mem_write_d), .no_write_d(no_write_d), .alu_flags(alu_flags),
    .cond_ex(cond_ex), .illegal_cond(illegal_cond), .flags(flags),
    .pc_src_m(pc_src_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .valid_m(valid_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [3:0] c, input logic [1:0] fw,
                       input logic pc, input logic rw, input logic mw, input logic nw,
                       input logic [3:0] af);
    ex_valid = ev; cond = c; flag_w = fw; pc_src_d = pc; reg_write_d = rw;
    mem_write_d = mw; no_write_d = nw; alu_flags = af;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pass bit per condition code (bit index = cond) for two flag states.
  logic [15:0] exp_1000 = 16'h6A9A;
  logic [15:0] exp_0111 = 16'h6A65;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_flags", flags, 4'b0000);
    chk("rst_pc", {3'b0, pc_src_m}, 4'd0);
    chk("rst_rw", {3'b0, reg_write_m}, 4'd0);
    chk("rst_mw", {3'b0, mem_write_m}, 4'd0);
    chk("rst_vm", {3'b0, valid_m}, 4'd0);
    chk("eq_z0", {3'b0, cond_ex}, 4'd0);

    // Set Z via AL, then EQ passes and writes a register.
    drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    chk("al_pass", {3'b0, cond_ex}, 4'd1);
    step();
    chk("flags_0100", flags, 4'b0100);
    chk("vm_after_al", {3'b0, valid_m}, 4'd1);
    drive(1'b1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("eq_z1", {3'b0, cond_ex}, 4'd1);
    step();
    chk("rw_eq", {3'b0, reg_write_m}, 4'd1);
    drive(1'b1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    step();
    chk("rw_nowrite", {3'b0, reg_write_m}, 4'd0);

    // CV-only write keeps N,Z.
    drive(1'b1, 4'hE, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011);
    step();
    chk("flags_0111", flags, 4'b0111);
    drive(1'b1, 4'h8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("hi", {3'b0, cond_ex}, 4'd0);
    drive(1'b1, 4'h9, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("ls", {3'b0, cond_ex}, 4'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk($sformatf("tbl0111_c%0d", i), {3'b0, cond_ex}, {3'b0, exp_0111[i]});
    end

    // N=1, V=0.
    drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    step();
    chk("flags_1000", flags, 4'b1000);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk($sformatf("tbl1000_c%0d", i), {3'b0, cond_ex}, {3'b0, exp_1000[i]});
      chk($sformatf("ill_c%0d", i), {3'b0, illegal_cond}, {3'b0, (i == 15)});
    end

    // Reserved condition: no flag write, no side effect.
    drive(1'b1, 4'hF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("rsvd_cx", {3'b0, cond_ex}, 4'd0);
    chk("rsvd_ill", {3'b0, illegal_cond}, 4'd1);
    step();
    chk("rsvd_flags", flags, 4'b1000);
    chk("rsvd_mw", {3'b0, mem_write_m}, 4'd0);
    drive(1'b0, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("rsvd_ill_nv", {3'b0, illegal_cond}, 4'd0);

    // Stall holds everything, release applies the write.
    stall = 1'b1;
    drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
    step();
    chk("stall_flags", flags, 4'b1000);
    chk("stall_mw", {3'b0, mem_write_m}, 4'd0);
    chk("stall_vm", {3'b0, valid_m}, 4'd1);
    stall = 1'b0;
    #1;
    step();
    chk("unstall_flags", flags, 4'b1111);
    chk("unstall_mw", {3'b0, mem_write_m}, 4'd1);

    // ex_valid=0 kills everything.
    drive(1'b0, 4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101);
    chk("nv_cx", {3'b0, cond_ex}, 4'd0);
    step();
    chk("nv_flags", flags, 4'b1111);
    chk("nv_vm", {3'b0, valid_m}, 4'd0);
    chk("nv_pc", {3'b0, pc_src_m}, 4'd0);

    // Flush kills the instruction.
    flush = 1'b1;
    drive(1'b1, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("flush_cx", {3'b0, cond_ex}, 4'd0);
    step();
    chk("flush_pc", {3'b0, pc_src_m}, 4'd0);
    chk("flush_vm", {3'b0, valid_m}, 4'd0);
    chk("flush_flags", flags, 4'b1111);

    // Load pc_src_m/valid_m, then flush under stall holds them.
    flush = 1'b0;
    drive(1'b1, 4'hE, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    chk("pc_set", {3'b0, pc_src_m}, 4'd1);
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("sf_cx", {3'b0, cond_ex}, 4'd0);
    step();
    chk("sf_pc", {3'b0, pc_src_m}, 4'd1);
    chk("sf_vm", {3'b0, valid_m}, 4'd1);
    chk("sf_flags", flags, 4'b1111);

    // Reset beats stall.
    reset = 1'b1;
    #1;
    step();
    chk("rs_flags", flags, 4'b0000);
    chk("rs_pc", {3'b0, pc_src_m}, 4'd0);
    chk("rs_vm", {3'b0, valid_m}, 4'd0);
    reset = 1'b0; stall = 1'b0; flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
